sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 193 +++++++++++++++++++
 tb/tb_sram_responder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: single-outstanding SRAM target with independent read and
// write request channels, a fixed response latency and byte-strobed writes.
// Reads and complete write requests are arbitrated round-robin in IDLE; the
// response is produced LATENCY cycles after the address handshake and held
// until the requester accepts it.
module sram_responder #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 64,
    parameter int                DEPTH   = 4096,
    parameter logic [ADDR_W-1:0] BASE    = 'h8000_0000,
    parameter int                LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,

    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,

    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                awvalid,
    input  logic                wvalid,
    output logic                awready,
    output logic                wready,

    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int              STRB_W     = DATA_W / 8;
    localparam int              BYTE_SH    = $clog2(STRB_W);
    localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] SPAN       = (ADDR_W+1)'(DEPTH * STRB_W);
    localparam logic [3:0]      CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [1:0]      RESP_OKAY  = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } stateT;

    stateT             state;
    logic [3:0]        cnt;
    // 1 when the most recently accepted transaction was a read
    logic              lastRead;

    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [STRB_W-1:0] wstrbQ;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wrReq;
    logic              idle;
    logic              grantRd;
    logic              grantWr;
    logic              capInRange;
    logic [IDX_W-1:0]  capIdx;
    logic              commitWr;

    // Address lies inside the window [BASE, BASE + DEPTH words); the offset
    // is compared one bit wider so a window ending at the top of the address
    // space does not wrap.
    function automatic logic addrInRange(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return (a >= BASE) && ({1'b0, off} < SPAN);
    endfunction

    // Word index of an address; byte-lane bits below the word are dropped.
    function automatic logic [IDX_W-1:0] wordIndex(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> BYTE_SH);
    endfunction

    // A write only counts as a request once both address and data are offered.
    assign wrReq   = awvalid && wvalid;
    assign idle    = (state == IDLE) && rst;
    // On a collision the type not serviced last wins.
    assign grantRd = arvalid && (!wrReq || !lastRead);
    assign grantWr = wrReq && !grantRd;

    assign arready = idle && grantRd;
    assign awready = idle && grantWr;
    assign wready  = idle && grantWr;

    assign capInRange = addrInRange(addrQ);
    assign capIdx     = wordIndex(addrQ);
    // Storage is written on the edge that raises bvalid, so a reset while
    // waiting discards the write entirely.
    assign commitWr   = (state == WR_WAIT) && (cnt == 4'd0) && capInRange;

    // Capture the request payload at the address handshake.
    always_ff @(posedge clk) begin
        if (arready) begin
            addrQ <= araddr;
        end else if (awready) begin
            addrQ  <= awaddr;
            wdataQ <= wdata;
            wstrbQ <= wstrb;
        end
    end

    // Byte-merged storage update; contents survive reset.
    always_ff @(posedge clk) begin
        if (commitWr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrbQ[b]) begin
                    mem[capIdx][8*b +: 8] <= wdataQ[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered response channel outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lastRead <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (arready) begin
                        state    <= RD_WAIT;
                        cnt      <= CNT_LOAD;
                        lastRead <= 1'b1;
                    end else if (awready) begin
                        state    <= WR_WAIT;
                        cnt      <= CNT_LOAD;
                        lastRead <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= RD_RESP;
                        rvalid <= 1'b1;
                        if (capInRange) begin
                            rdata <= mem[capIdx];
                            rresp <= RESP_OKAY;
                        end else begin
                            rdata <= '0;
                            rresp <= RESP_SLVERR;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        state  <= IDLE;
                        rvalid <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= WR_RESP;
                        bvalid <= 1'b1;
                        bresp  <= capInRange ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        state  <= IDLE;
                        bvalid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed scenarios plus randomized traffic, all
// checked by a cycle monitor against a word-level memory model.
module tb_sram_responder;

    localparam int          ADDR_W  = 32;
    localparam int          DATA_W  = 64;
    localparam int          DEPTH   = 4096;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        awvalid;
    logic        wvalid;
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    sram_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .BASE   (BASE),
        .LATENCY(LATENCY)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .awaddr (awaddr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .awvalid(awvalid),
        .wvalid (wvalid),
        .awready(awready),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors    = 0;
    int miscompares = 0;

    task automatic checkVec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] modelMem [int];
    bit          lastRead  = 1'b0;
    bit          busy      = 1'b0;
    bit          isRd      = 1'b0;
    bit          committed = 1'b1;
    int          hs        = 0;
    logic [63:0] expData   = '0;
    logic [1:0]  expResp   = 2'b00;
    bit          expKnown  = 1'b0;
    bit          wIn       = 1'b0;
    int          wIdx      = 0;
    logic [63:0] wData     = '0;
    logic [7:0]  wStrb     = '0;

    function automatic bit inRng(input logic [31:0] a);
        longint unsigned x;
        longint unsigned lo;
        x  = {32'd0, a};
        lo = {32'd0, BASE};
        return (x >= lo) && (x < lo + DEPTH * 8);
    endfunction

    function automatic int idxOf(input logic [31:0] a);
        longint unsigned x;
        x = {32'd0, a} - {32'd0, BASE};
        return int'(x / 8);
    endfunction

    task automatic commitModel();
        logic [63:0] v;
        committed = 1'b1;
        if (wIn) begin
            if (wStrb == 8'hFF) begin
                modelMem[wIdx] = wData;
            end else if (modelMem.exists(wIdx)) begin
                v = modelMem[wIdx];
                for (int b = 0; b < 8; b++)
                    if (wStrb[b]) v[8*b +: 8] = wData[8*b +: 8];
                modelMem[wIdx] = v;
            end
        end
    endtask

    // Cycle monitor: sampled mid-cycle, compares every handshake/response
    // output against the model's view of the outstanding transaction.
    always @(negedge clk) begin : monitor
        bit wrReq;
        bit gRd;
        bit gWr;
        bit expRv;
        bit expBv;
        if (!rst) begin
            if (busy && !isRd && !committed && (cyc - hs >= LATENCY)) commitModel();
            busy     = 1'b0;
            lastRead = 1'b0;
            checkVec("rst_arready", arready, 0);
            checkVec("rst_awready", awready, 0);
            checkVec("rst_wready", wready, 0);
            checkVec("rst_rvalid", rvalid, 0);
            checkVec("rst_bvalid", bvalid, 0);
        end else begin
            expRv = busy && isRd && (cyc - hs >= LATENCY);
            expBv = busy && !isRd && (cyc - hs >= LATENCY);
            checkVec("rvalid", rvalid, expRv);
            checkVec("bvalid", bvalid, expBv);
            if (expRv) begin
                if (expKnown) checkVec("rdata", rdata, expData);
                checkVec("rresp", rresp, expResp);
            end
            if (expBv) begin
                if (!committed) commitModel();
                checkVec("bresp", bresp, expResp);
            end
            wrReq = awvalid && wvalid;
            gRd   = !busy && arvalid && (!wrReq || !lastRead);
            gWr   = !busy && wrReq && !(arvalid && (!wrReq || !lastRead));
            checkVec("arready", arready, gRd);
            checkVec("awready", awready, gWr);
            checkVec("wready", wready, gWr);
            if ((expRv && rready) || (expBv && bready)) begin
                busy = 1'b0;
            end else if (gRd) begin
                busy     = 1'b1;
                isRd     = 1'b1;
                hs       = cyc + 1;
                lastRead = 1'b1;
                if (inRng(araddr)) begin
                    expResp  = 2'b00;
                    expKnown = modelMem.exists(idxOf(araddr));
                    expData  = expKnown ? modelMem[idxOf(araddr)] : 64'd0;
                end else begin
                    expResp  = 2'b10;
                    expKnown = 1'b1;
                    expData  = 64'd0;
                end
            end else if (gWr) begin
                busy      = 1'b1;
                isRd      = 1'b0;
                hs        = cyc + 1;
                lastRead  = 1'b0;
                committed = 1'b0;
                wIn       = inRng(awaddr);
                wIdx      = wIn ? idxOf(awaddr) : 0;
                wData     = wdata;
                wStrb     = wstrb;
                expResp   = wIn ? 2'b00 : 2'b10;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic doWrite(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [1:0] resp, output int lat);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        if (!awready) checkVec("wr_accept_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic doRead(input logic [31:0] a, input int stall,
                          output logic [63:0] data, output logic [1:0] resp, output int lat);
        int n;
        araddr = a; arvalid = 1'b1; rready = (stall == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) checkVec("rd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        data = rdata;
        resp = rresp;
        if (stall > 0) begin
            arvalid = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                checkVec("stall_rvalid", rvalid, 1);
                checkVec("stall_rdata", rdata, expData);
                checkVec("stall_rresp", rresp, expResp);
                checkVec("stall_arready", arready, 0);
            end
            rready = 1'b1;
        end
        @(posedge clk); #1;
        rready = 1'b0;
        if (stall > 0) begin
            checkVec("post_rvalid", rvalid, 0);
            checkVec("post_arready", arready, 1);
            arvalid = 1'b0;
        end
    endtask

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 9))
            0:       return BASE - 32'(8 * $urandom_range(1, 4));
            1:       return BASE + 32'(DEPTH * 8) + 32'($urandom_range(0, 64));
            default: return BASE + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(0, 7));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] d;
        logic [1:0]  r;
        int          l;
        int          n;
        string       order;
        logic [63:0] prior;

        rst = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        checkVec("reset_arready", arready, 0);
        checkVec("reset_awready", awready, 0);
        checkVec("reset_wready", wready, 0);
        checkVec("reset_rvalid", rvalid, 0);
        checkVec("reset_bvalid", bvalid, 0);
        checkVec("reset_rdata", rdata, 0);
        checkVec("reset_rresp", rresp, 0);
        checkVec("reset_bresp", bresp, 0);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Fill the words used by the rest of the bench.
        for (int i = 0; i < 16; i++) begin
            doWrite(BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF, r, l);
            checkVec("fill_bresp", r, 2'b00);
            checkVec("fill_latency", l, LATENCY);
        end

        // Full write then read back.
        doWrite(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, r, l);
        checkVec("full_wr_bresp", r, 2'b00);
        checkVec("full_wr_latency", l, LATENCY);
        doRead(32'h8000_0010, 0, d, r, l);
        checkVec("full_rd_data", d, 64'h1122_3344_5566_7788);
        checkVec("full_rd_rresp", r, 2'b00);
        checkVec("full_rd_latency", l, LATENCY);

        // Partial strobe.
        doWrite(32'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, r, l);
        checkVec("part_wr_bresp", r, 2'b00);
        doRead(32'h8000_0010, 0, d, r, l);
        checkVec("part_rd_data", d, 64'h1122_3344_BBBB_BBBB);

        // Low address bits ignored.
        doRead(32'h8000_0013, 0, d, r, l);
        checkVec("lowbits_rd_data", d, 64'h1122_3344_BBBB_BBBB);

        // Out-of-range accesses.
        doRead(32'h7FFF_FFF8, 0, d, r, l);
        checkVec("oor_rd_rresp", r, 2'b10);
        checkVec("oor_rd_data", d, 64'd0);
        doWrite(32'h8000_8000, {$urandom, $urandom}, 8'hFF, r, l);
        checkVec("oor_wr_bresp", r, 2'b10);
        doRead(BASE, 0, d, r, l);
        checkVec("word0_unchanged", d, modelMem[0]);
        doRead(32'h8000_8000, 0, d, r, l);
        checkVec("top_edge_rresp", r, 2'b10);

        // Last word of the window.
        doWrite(32'h8000_7FF8, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, r, l);
        checkVec("last_wr_bresp", r, 2'b00);
        doRead(32'h8000_7FFF, 0, d, r, l);
        checkVec("last_rd_data", d, 64'hDEAD_BEEF_0BAD_F00D);
        checkVec("last_rd_rresp", r, 2'b00);

        // Zero strobe leaves storage alone.
        doWrite(32'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'h00, r, l);
        checkVec("zero_strb_bresp", r, 2'b00);
        doRead(32'h8000_0010, 0, d, r, l);
        checkVec("zero_strb_data", d, 64'h1122_3344_BBBB_BBBB);

        // Back-pressured read response.
        doRead(BASE + 32'h8, 5, d, r, l);
        checkVec("stall_rd_data", d, modelMem[1]);

        // Read and write held together: alternation, read first after a write.
        doWrite(BASE + 32'h20, {$urandom, $urandom}, 8'hFF, r, l);
        araddr = BASE + 32'h28; awaddr = BASE + 32'h28;
        wdata = 64'h5A5A_0F0F_A5A5_F0F0; wstrb = 8'hFF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        order = "";
        n = 0;
        while (order.len() < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (arready) order = {order, "R"};
            if (awready) order = {order, "W"};
        end
        checkVec("arb_order_rwrw", order == "RWRW", 1);
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rready = 1'b0; bready = 1'b0;

        // Reset while a write is waiting: the write is lost.
        prior = modelMem[3];
        awaddr = BASE + 32'h18; wdata = ~prior; wstrb = 8'hFF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        if (!awready) checkVec("rst_wr_accept_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checkVec("dropped_bvalid", bvalid, 0);
        end
        bready = 1'b0;
        doRead(BASE + 32'h18, 0, d, r, l);
        checkVec("dropped_wr_data", d, prior);

        // Randomized traffic, including unpaired write halves and reset pulses.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) != 0);
            araddr  = randAddr();
            awaddr  = randAddr();
            wdata   = {$urandom, $urandom};
            wstrb   = 8'($urandom);
            arvalid = ($urandom_range(0, 2) == 0);
            awvalid = ($urandom_range(0, 1) == 0);
            wvalid  = ($urandom_range(0, 1) == 0);
            rready  = ($urandom_range(0, 1) == 0);
            bready  = ($urandom_range(0, 1) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rready = 1'b1; bready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
